// File: rtl/ppc_pkg.sv
// Shared types and widths for the PPC core front end.
package ppc_pkg;

    localparam int INST_W    = 32;
    localparam int ADDR_W    = 64;
    localparam int DW_ADDR_W = 61;

    // One buffered fetch result: byte address plus the instruction word.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Big-endian word select: address bit 2 clear picks the upper half.
    function automatic logic [INST_W-1:0] sel_word(input logic [63:0] dw, input logic lo);
        return lo ? dw[31:0] : dw[63:32];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode. Flush wins over push/pop;
// the head is a plain register read so downstream sees no input paths.
module fetch_fifo
    import ppc_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, issues one read per cycle on mem port 0,
// buffers results and hands them to decode. Redirect flushes everything.
module fetch
    import ppc_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        memReadEn0,
    output logic [63:3] memReadAddr0,
    input  logic [63:0] memReadData0,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state;
    logic [63:0]   pc;
    logic          req_q;
    logic [63:0]   req_pc_q;
    logic [CW-1:0] count;
    logic          issue;
    logic          push;
    logic          pop;
    fetch_entry_t  wdata;
    fetch_entry_t  head;

    // In-flight request counts against capacity so a push never finds the FIFO full.
    assign issue = (state == RUN) && !halt && !redirect_valid &&
                   ((count + CW'(req_q)) < CW'(FIFO_DEPTH));

    assign memReadEn0   = issue && rst_n;
    assign memReadAddr0 = pc[63:3];

    // A response arriving in a redirect cycle belongs to the old path.
    assign push        = req_q && !redirect_valid;
    assign pop         = inst_valid && inst_ready && !redirect_valid;
    assign wdata.pc    = req_pc_q;
    assign wdata.inst  = sel_word(memReadData0, req_pc_q[2]);

    // Run/halt state, PC and the one-deep outstanding-request tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else begin
            case (state)
                RUN:     if (halt)  state <= HALTED;
                HALTED:  if (!halt) state <= RUN;
                default: state <= RUN;
            endcase
            if (redirect_valid) begin
                pc    <= redirect_pc & ~64'h3;
                req_q <= 1'b0;
            end else begin
                req_q <= issue;
                if (issue) begin
                    req_pc_q <= pc;
                    pc       <= pc + 64'd4;
                end
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    assign inst_valid = (count != '0);
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch with a scoreboard of expected {pc, inst} pairs.
module tb_fetch;

    localparam logic [63:0] RST_PC = 64'h100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        memReadEn0;
    logic [63:3] memReadAddr0;
    logic [63:0] memReadData0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_pc [$];
    logic [31:0] sb_inst [$];
    logic [63:0] exp_pc;

    fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .memReadEn0     (memReadEn0),
        .memReadAddr0   (memReadAddr0),
        .memReadData0   (memReadData0),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    // Memory image: word at byte address a is a recognisable function of a.
    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] dw_at(input logic [63:3] d);
        return {word_at({d, 3'b000}), word_at({d, 3'b100})};
    endfunction

    // One-cycle-latency memory; idle cycles return junk so stray pushes show up.
    always @(posedge clk) begin
        if (memReadEn0) memReadData0 <= dw_at(memReadAddr0);
        else            memReadData0 <= 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: record each issue, compare each accepted head, drop on redirect/reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_pc.delete();
            sb_inst.delete();
            exp_pc = RST_PC;
        end else if (redirect_valid) begin
            chk("redir_noissue", {63'b0, memReadEn0}, 64'd0);
            sb_pc.delete();
            sb_inst.delete();
            exp_pc = redirect_pc & ~64'h3;
        end else begin
            if (halt) chk("halt_noissue", {63'b0, memReadEn0}, 64'd0);
            if (inst_valid && inst_ready) begin
                if (sb_pc.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    chk("sb_pc", inst_pc, sb_pc.pop_front());
                    chk("sb_inst", {32'b0, inst}, {32'b0, sb_inst.pop_front()});
                end
            end
            if (memReadEn0) begin
                chk("sb_addr", {3'b0, memReadAddr0}, {3'b0, exp_pc[63:3]});
                sb_pc.push_back(exp_pc);
                sb_inst.push_back(word_at(exp_pc));
                exp_pc = exp_pc + 64'd4;
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b1;
        #2;
        chk("rst_en", {63'b0, memReadEn0}, 64'd0);
        chk("rst_valid", {63'b0, inst_valid}, 64'd0);
        chk("rst_inst", {32'b0, inst}, 64'd0);
        chk("rst_pc", inst_pc, 64'd0);
        repeat (2) tick();

        // Reset release and first fetches.
        rst_n = 1'b1;
        #1;
        chk("c0_en", {63'b0, memReadEn0}, 64'd1);
        chk("c0_addr", {3'b0, memReadAddr0}, 64'h20);
        tick();
        chk("c1_addr", {3'b0, memReadAddr0}, 64'h20);
        chk("c1_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        chk("c2_addr", {3'b0, memReadAddr0}, 64'h21);
        chk("c2_valid", {63'b0, inst_valid}, 64'd1);
        chk("c2_pc", inst_pc, 64'h100);
        chk("c2_inst_hi", {32'b0, inst}, 64'h5A5A_0100);
        tick();
        chk("c3_pc", inst_pc, 64'h104);
        chk("c3_inst_lo", {32'b0, inst}, 64'h5A5A_0104);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stream_valid", {63'b0, inst_valid}, 64'd1);
        end

        // Backpressure fills the buffer and stops issue.
        inst_ready = 1'b0;
        repeat (10) tick();
        chk("stall_count", {61'b0, dut.count}, 64'd4);
        chk("stall_en", {63'b0, memReadEn0}, 64'd0);
        inst_ready = 1'b1;
        repeat (8) tick();

        // Redirect with three buffered and one in flight.
        inst_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (dut.count == 3 && dut.req_q) found = 1'b1;
        end
        chk("poll_full_inflight", {63'b0, found}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 64'h2003; inst_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("redir_t1_valid", {63'b0, inst_valid}, 64'd0);
        chk("redir_t1_en", {63'b0, memReadEn0}, 64'd1);
        chk("redir_t1_addr", {3'b0, memReadAddr0}, 64'h400);
        tick();
        chk("redir_t2_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        chk("redir_t3_valid", {63'b0, inst_valid}, 64'd1);
        chk("redir_t3_pc", inst_pc, 64'h2000);
        repeat (4) tick();

        // Halt pulse of five cycles.
        halt = 1'b1;
        #1;
        chk("halt_en", {63'b0, memReadEn0}, 64'd0);
        repeat (4) tick();
        tick();
        halt = 1'b0;
        #1;
        chk("halt_exit_en", {63'b0, memReadEn0}, 64'd0);
        chk("halt_drained", 64'(sb_pc.size()), 64'd0);
        tick();
        chk("halt_resume_en", {63'b0, memReadEn0}, 64'd1);
        repeat (5) tick();

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr", {3'b0, memReadAddr0}, 64'h1FFF_FFFF_FFFF_FFFF);
        tick();
        tick();
        chk("wrap_pc_top", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_pc_zero", inst_pc, 64'h0);
        repeat (3) tick();

        // Asynchronous reset with three entries buffered.
        inst_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (dut.count == 3) found = 1'b1;
        end
        chk("poll_three", {63'b0, found}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'b0, inst_valid}, 64'd0);
        chk("arst_inst", {32'b0, inst}, 64'd0);
        chk("arst_pc", inst_pc, 64'd0);
        chk("arst_en", {63'b0, memReadEn0}, 64'd0);
        tick();
        rst_n = 1'b1; inst_ready = 1'b1;
        #1;
        chk("rerun_en", {63'b0, memReadEn0}, 64'd1);
        chk("rerun_addr", {3'b0, memReadAddr0}, 64'h20);
        tick();
        tick();
        chk("rerun_pc", inst_pc, 64'h100);
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
